inout_bus_arbiter: RTL and testbench

Sequences ownership of one shared bidirectional (inout) net among N on-chip drivers, e.g. a local driver, a child-instance (lowconn) driver and a parent-side (highconn) driver. It grants at most one driver at a time, inserts a mandatory no-driver turnaround gap between owners, and revokes a grant that exceeds a hold limit. The block sits beside the inout port and drives the per-driver output enables, so the net never resolves to x from driver contention.

---
 rtl/inout_bus_arbiter_pkg.sv | 27 ++
 rtl/inout_bus_arbiter_rr_pick.sv | 39 +++
 rtl/inout_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_inout_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inout_bus_arbiter_pkg.sv
// Shared types and helpers for the inout bus arbiter.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package inout_arb_pkg;

  // FSM states: no owner, one owner driving, mandatory no-driver gap.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Default parameter values for the arbiter.
  localparam int DEF_TURN     = 1;
  localparam int DEF_MAX_HOLD = 16;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inout_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr wins.
// Latency: 0 cycles, purely combinational; the caller registers the result.
// Backpressure: none; o_win is all-zero when no request is set.
module rr_pick
  import inout_arb_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = ceil_log2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic [IW-1:0] o_win_idx
);

  int          w_sum;
  logic [IW-1:0] w_idx;
  logic        w_found;

  // Scan requests starting at the pointer, wrapping past N-1 back to 0.
  always_comb begin
    o_win     = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IW'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_win[w_idx] = 1'b1;
        o_win_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/inout_bus_arbiter.sv
// Grants one driver at a time on a shared inout net, with a no-driver gap and a hold limit.
// Latency: request sampled in IDLE -> grant/oe one edge later; release condition -> oe low one edge later.
// Backpressure: requests wait until IDLE; owner is revoked after MAX_HOLD cycles with a timeout pulse.
module inout_bus_arbiter
  import inout_arb_pkg::*;
#(
  parameter  int N        = 3,
  parameter  int TURN     = DEF_TURN,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW       = ceil_log2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_done,
  output logic [N-1:0]  o_gnt,
  output logic [N-1:0]  o_oe,
  output logic          o_busy,
  output logic          o_timeout,
  output logic [IW-1:0] o_owner
);

  localparam int HW = (ceil_log2(MAX_HOLD) > 0) ? ceil_log2(MAX_HOLD) : 1;
  localparam int TW = (ceil_log2(TURN) > 0) ? ceil_log2(TURN) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  arb_state_t    r_state;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_oe;
  logic          r_busy;
  logic          r_timeout;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_turn;

  arb_state_t    w_state_nxt;
  logic [N-1:0]  w_gnt_nxt;
  logic          w_busy_nxt;
  logic          w_timeout_nxt;
  logic [IW-1:0] w_owner_nxt;
  logic [IW-1:0] w_ptr_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [TW-1:0] w_turn_nxt;

  logic [N-1:0]  w_win;
  logic [IW-1:0] w_win_idx;
  logic          w_any_req;
  logic          w_own_req;
  logic          w_own_done;
  logic          w_hold_max;
  logic          w_release;

  rr_pick #(.N(N)) u_rr_pick (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx)
  );

  // Only the current owner's req/done bits can end a grant.
  assign w_any_req  = |i_req;
  assign w_own_req  = i_req[r_owner];
  assign w_own_done = i_done[r_owner];
  assign w_hold_max = (r_hold == HOLD_LAST);
  assign w_release  = !w_own_req || w_own_done || w_hold_max;

  // Next-state and next-output logic; every output comes from a register.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_turn_nxt    = r_turn;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_win;
          w_owner_nxt = w_win_idx;
          w_hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt   = ST_TURN;
          w_gnt_nxt     = '0;
          w_ptr_nxt     = (r_owner == LAST_IDX) ? '0 : IW'(r_owner + 1'b1);
          w_turn_nxt    = TURN_LOAD;
          // A voluntary release wins over a coincident hold-limit revoke.
          w_timeout_nxt = w_hold_max && w_own_req && !w_own_done;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      ST_TURN: begin
        if (r_turn == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_turn_nxt = r_turn - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; reset lands directly in IDLE with no gap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_oe      <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_turn    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_oe      <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_turn    <= w_turn_nxt;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_oe      = r_oe;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;
  assign o_owner   = r_owner;

endmodule

// File: tb/tb_inout_bus_arbiter.sv
// Self-checking bench for inout_bus_arbiter with a grant-order scoreboard.
// Two instances: TURN=1/MAX_HOLD=4 and TURN=3/MAX_HOLD=16.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_inout_bus_arbiter;

  logic       clk;
  logic       rst, rst3;
  logic [2:0] req, done, req3, done3;
  logic [2:0] gnt, oe, gnt3, oe3;
  logic       busy, tmo, busy3, tmo3;
  logic [1:0] owner, owner3;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];

  inout_bus_arbiter #(.N(3), .TURN(1), .MAX_HOLD(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
    .o_gnt(gnt), .o_oe(oe), .o_busy(busy), .o_timeout(tmo), .o_owner(owner)
  );

  inout_bus_arbiter #(.N(3), .TURN(3), .MAX_HOLD(16)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_done(done3),
    .o_gnt(gnt3), .o_oe(oe3), .o_busy(busy3), .o_timeout(tmo3), .o_owner(owner3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rst3 = 1'b1;
    req = '0; done = '0; req3 = '0; done3 = '0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (oe !== 3'b000) begin n_err++; $display("FAIL reset_oe: got %b want 000", oe); end
    n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_cmp++; if (oe3 !== 3'b000) begin n_err++; $display("FAIL reset_oe3: got %b want 000", oe3); end
    n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL reset_busy3: got %b want 0", busy3); end
  endtask

  task automatic test_single();
    logic [2:0] e;
    do_reset();
    tick();
    tick();                                   // cycle 2
    req = 3'b001;
    exp_q.push_back(3'b001);
    tick();                                   // cycle 3
    if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL single_sb: queue empty"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (oe !== e) begin n_err++; $display("FAIL single_oe: got %b want %b", oe, e); end
      n_cmp++; if (gnt !== e) begin n_err++; $display("FAIL single_gnt: got %b want %b", gnt, e); end
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    tick(); tick(); tick();                   // cycle 6
    n_cmp++; if (oe !== 3'b001) begin n_err++; $display("FAIL single_hold: got %b want 001", oe); end
    req = 3'b000;
    tick();                                   // cycle 7: released, in TURN
    n_cmp++; if (oe !== 3'b000) begin n_err++; $display("FAIL single_release: got %b want 000", oe); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_turn_busy: got %b want 1", busy); end
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL single_no_timeout: got %b want 0", tmo); end
    tick();                                   // cycle 8
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] e;
    logic [2:0] prev;
    int hold, gap, ngr;
    bit expired;
    do_reset();
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    exp_q.push_back(3'b100); exp_q.push_back(3'b001);
    prev = '0; hold = 0; gap = 0; ngr = 0; expired = 1'b1;
    req = 3'b111;
    for (int c = 0; c < 80; c++) begin
      tick();
      n_cmp++; if ($countones(oe) > 1) begin n_err++; $display("FAIL sim_onehot: got %b want at most one bit", oe); end
      if (oe != 3'b000) begin
        if (prev == 3'b000) begin
          if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL sim_sb: unexpected grant %b", oe); end
          else begin
            e = exp_q.pop_front();
            n_cmp++; if (oe !== e) begin n_err++; $display("FAIL sim_order: got %b want %b", oe, e); end
          end
          if (ngr > 0) begin
            n_cmp++; if (gap < 2) begin n_err++; $display("FAIL sim_gap: got %0d idle cycles want >= 2", gap); end
          end
          ngr++;
          hold = 1;
          if (ngr == 4) req = 3'b000;
        end else begin
          hold++;
          if (hold == 2) req = req & ~oe;
        end
        gap = 0;
      end else begin
        gap++;
        if (ngr < 4) req = 3'b111;
        else if (busy == 1'b0) begin expired = 1'b0; break; end
      end
      prev = oe;
    end
    n_cmp++; if (expired) begin n_err++; $display("FAIL sim_complete: got %0d grants want 4", ngr); end
    req = 3'b000;
  endtask

  task automatic test_done();
    logic [2:0] e;
    bit expired;
    do_reset();
    req = 3'b010;
    exp_q.push_back(3'b010);
    tick();                                   // cycle 1: owner 1 granted
    if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL done_sb: queue empty"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (oe !== e) begin n_err++; $display("FAIL done_grant: got %b want %b", oe, e); end
    end
    done = 3'b100;                            // non-owner done
    tick();
    done = 3'b000;
    n_cmp++; if (oe !== 3'b010) begin n_err++; $display("FAIL done_foreign_ignored: got %b want 010", oe); end
    done = 3'b010;
    tick();
    done = 3'b000;
    n_cmp++; if (oe !== 3'b000) begin n_err++; $display("FAIL done_release: got %b want 000", oe); end
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL done_no_timeout: got %b want 0", tmo); end
    n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL done_owner: got %0d want 1", owner); end
    req = 3'b000;
    expired = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy == 1'b0) begin expired = 1'b0; break; end
    end
    n_cmp++; if (expired) begin n_err++; $display("FAIL done_idle: got busy=1 want 0"); end
  endtask

  task automatic test_timeout();
    logic [2:0] e;
    int run, gap;
    do_reset();
    req = 3'b001;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    tick();
    if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL tmo_sb: queue empty"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (oe !== e) begin n_err++; $display("FAIL tmo_grant: got %b want %b", oe, e); end
    end
    run = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (oe == 3'b000) break;
      run++;
    end
    n_cmp++; if (run != 4) begin n_err++; $display("FAIL tmo_hold_len: got %0d want 4", run); end
    n_cmp++; if (tmo !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: got %b want 1", tmo); end
    gap = 1;
    tick();
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL tmo_single_cycle: got %b want 0", tmo); end
    if (oe == 3'b000) begin
      gap++;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (oe != 3'b000) break;
        gap++;
      end
    end
    n_cmp++; if (gap != 2) begin n_err++; $display("FAIL tmo_gap: got %0d want 2", gap); end
    if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL tmo_sb2: queue empty"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (oe !== e) begin n_err++; $display("FAIL tmo_regrant: got %b want %b", oe, e); end
    end
    req = 3'b000;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b100;
    tick();                                   // first GRANT cycle
    tick();                                   // second GRANT cycle
    n_cmp++; if (oe !== 3'b100) begin n_err++; $display("FAIL rstmid_pre: got %b want 100", oe); end
    n_cmp++; if (owner !== 2'd2) begin n_err++; $display("FAIL rstmid_owner_pre: got %0d want 2", owner); end
    rst = 1'b1;
    req = 3'b000;
    tick();
    n_cmp++; if (oe !== 3'b000) begin n_err++; $display("FAIL rstmid_oe: got %b want 000", oe); end
    n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL rstmid_owner: got %0d want 0", owner); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    req = 3'b010;
    tick();
    n_cmp++; if (oe !== 3'b010) begin n_err++; $display("FAIL rstmid_regrant: got %b want 010", oe); end
    n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL rstmid_owner_post: got %0d want 1", owner); end
    req = 3'b000;
    tick(); tick(); tick();
  endtask

  task automatic test_turn3();
    logic [2:0] e;
    do_reset();
    req3 = 3'b001;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    tick();
    if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL turn3_sb: queue empty"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (oe3 !== e) begin n_err++; $display("FAIL turn3_grant: got %b want %b", oe3, e); end
    end
    req3 = 3'b000;
    tick();                                   // first TURN cycle
    req3 = 3'b010;                            // arrives during TURN
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      n_cmp++; if (oe3 !== 3'b000) begin n_err++; $display("FAIL turn3_gap_oe: cycle %0d got %b want 000", c, oe3); end
      n_cmp++; if (busy3 !== 1'b1) begin n_err++; $display("FAIL turn3_gap_busy: cycle %0d got %b want 1", c, busy3); end
    end
    tick();                                   // IDLE cycle
    n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL turn3_idle: got %b want 0", busy3); end
    n_cmp++; if (oe3 !== 3'b000) begin n_err++; $display("FAIL turn3_idle_oe: got %b want 000", oe3); end
    tick();
    if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL turn3_sb2: queue empty"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if (oe3 !== e) begin n_err++; $display("FAIL turn3_regrant: got %b want %b", oe3, e); end
    end
    req3 = 3'b000;
    tick(); tick(); tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    req = '0; done = '0; req3 = '0; done3 = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_done();
    test_timeout();
    test_reset_mid();
    test_turn3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
